// File: rtl/branch_cond_ctrl.sv
// Branch-condition sequencer for the multicycle CPU: drives the mux_CB selector, waits for the
// ALU flags, resolves taken/not-taken or aborts on timeout, and keeps saturating statistics.
module branch_cond_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_req,
  input  logic [1:0]       br_type,
  input  logic             flags_valid,
  input  logic             cb_in,
  input  logic             cnt_clr,
  output logic [1:0]       cb_sel,
  output logic             br_busy,
  output logic             pc_write_cond,
  output logic             br_done,
  output logic             br_taken,
  output logic             br_timeout,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt;
  logic [1:0] w_cb_sel;
  logic       w_pc_write;
  logic       w_done;
  logic       w_taken;
  logic       w_timeout;

  // Next-state and next-output decode; pulses are computed here so they can be registered
  always_comb begin
    w_next     = r_state;
    w_wait_cnt = r_wait_cnt;
    w_cb_sel   = cb_sel;
    w_pc_write = 1'b0;
    w_done     = 1'b0;
    w_taken    = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (br_req) begin
          w_next     = S_WAIT;
          w_cb_sel   = br_type;
          w_wait_cnt = 8'd0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        // flags arriving in the expiry cycle still resolve the branch
        if (flags_valid) begin
          w_next     = S_DONE;
          w_done     = 1'b1;
          w_taken    = cb_in;
          w_pc_write = cb_in;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next    = S_ABORT;
          w_done    = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_wait_cnt = r_wait_cnt + 8'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter, selector and registered pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 8'd0;
      cb_sel        <= 2'b00;
      br_busy       <= 1'b0;
      pc_write_cond <= 1'b0;
      br_done       <= 1'b0;
      br_taken      <= 1'b0;
      br_timeout    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_wait_cnt    <= w_wait_cnt;
      cb_sel        <= w_cb_sel;
      br_busy       <= (w_next != S_IDLE);
      pc_write_cond <= w_pc_write;
      br_done       <= w_done;
      br_taken      <= w_taken;
      br_timeout    <= w_timeout;
    end
  end

  // Saturating statistics, bumped while DONE is held; clear beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt    <= {CNT_W{1'b0}};
      nottaken_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      taken_cnt    <= {CNT_W{1'b0}};
      nottaken_cnt <= {CNT_W{1'b0}};
    end else if (r_state == S_DONE) begin
      if (br_taken) begin
        if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        if (nottaken_cnt != CNT_MAX) nottaken_cnt <= nottaken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_branch_cond_ctrl.sv
// Directed self-checking bench for branch_cond_ctrl (narrow counters to reach saturation quickly).
module tb_branch_cond_ctrl;

  logic       clk;
  logic       reset;
  logic       br_req;
  logic [1:0] br_type;
  logic       flags_valid;
  logic       cb_in;
  logic       cnt_clr;
  logic [1:0] cb_sel;
  logic       br_busy;
  logic       pc_write_cond;
  logic       br_done;
  logic       br_taken;
  logic       br_timeout;
  logic [1:0] taken_cnt;
  logic [1:0] nottaken_cnt;

  int errors = 0;
  int checks = 0;

  branch_cond_ctrl #(.CNT_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .br_req(br_req), .br_type(br_type),
    .flags_valid(flags_valid), .cb_in(cb_in), .cnt_clr(cnt_clr),
    .cb_sel(cb_sel), .br_busy(br_busy), .pc_write_cond(pc_write_cond),
    .br_done(br_done), .br_taken(br_taken), .br_timeout(br_timeout),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one quick branch; checks the resolution pulse
  task automatic do_branch(input logic [1:0] t, input logic cb);
    br_req = 1'b1; br_type = t;
    tick();
    br_req = 1'b0; flags_valid = 1'b1; cb_in = cb;
    tick();
    checks++;
    if (br_done !== 1'b1 || pc_write_cond !== cb || br_taken !== cb) begin
      errors++;
      $display("FAIL do_branch: done=%b pc=%b taken=%b required done=1 pc=%b taken=%b",
               br_done, pc_write_cond, br_taken, cb, cb);
    end
    flags_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; br_req = 1'b0; br_type = 2'b00; flags_valid = 1'b0; cb_in = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    checks++;
    if ({cb_sel, br_busy, pc_write_cond, br_done, br_taken, br_timeout, taken_cnt, nottaken_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset: outputs=%b required all zero",
               {cb_sel, br_busy, pc_write_cond, br_done, br_taken, br_timeout, taken_cnt, nottaken_cnt});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_taken_beq();
    br_req = 1'b1; br_type = 2'b00;
    tick();
    checks++;
    if (br_busy !== 1'b1 || br_done !== 1'b0 || cb_sel !== 2'b00) begin
      errors++;
      $display("FAIL beq_wait: busy=%b done=%b sel=%b required 1 0 00", br_busy, br_done, cb_sel);
    end
    br_req = 1'b0; flags_valid = 1'b1; cb_in = 1'b1;
    tick();
    checks++;
    if ({pc_write_cond, br_done, br_taken, br_timeout} !== 4'b1110) begin
      errors++;
      $display("FAIL beq_pulse: pc/done/taken/to=%b required 1110",
               {pc_write_cond, br_done, br_taken, br_timeout});
    end
    flags_valid = 1'b0; cb_in = 1'b0;
    tick();
    checks++;
    if (taken_cnt !== 2'd1 || br_done !== 1'b0 || br_busy !== 1'b0 || pc_write_cond !== 1'b0) begin
      errors++;
      $display("FAIL beq_after: taken_cnt=%0d done=%b busy=%b pc=%b required 1 0 0 0",
               taken_cnt, br_done, br_busy, pc_write_cond);
    end
  endtask

  task automatic test_not_taken_bne();
    br_req = 1'b1; br_type = 2'b01;
    tick();
    br_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (cb_sel !== 2'b01 || br_busy !== 1'b1 || br_done !== 1'b0) begin
      errors++;
      $display("FAIL bne_wait: sel=%b busy=%b done=%b required 01 1 0", cb_sel, br_busy, br_done);
    end
    flags_valid = 1'b1; cb_in = 1'b0;
    tick();
    checks++;
    if ({pc_write_cond, br_done, br_taken, br_timeout} !== 4'b0100) begin
      errors++;
      $display("FAIL bne_pulse: pc/done/taken/to=%b required 0100",
               {pc_write_cond, br_done, br_taken, br_timeout});
    end
    flags_valid = 1'b0;
    tick();
    checks++;
    if (nottaken_cnt !== 2'd1 || taken_cnt !== 2'd1) begin
      errors++;
      $display("FAIL bne_cnt: nottaken=%0d taken=%0d required 1 1", nottaken_cnt, taken_cnt);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    br_req = 1'b1; br_type = 2'b10;
    tick();
    br_req = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (br_done !== 1'b0 || br_busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d cycles resolved or idle before expiry required 0", early);
    end
    tick();
    checks++;
    if ({pc_write_cond, br_done, br_taken, br_timeout} !== 4'b0101) begin
      errors++;
      $display("FAIL timeout_pulse: pc/done/taken/to=%b required 0101",
               {pc_write_cond, br_done, br_taken, br_timeout});
    end
    tick();
    checks++;
    if (taken_cnt !== 2'd1 || nottaken_cnt !== 2'd1 || br_busy !== 1'b0 || br_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: taken=%0d nottaken=%0d busy=%b to=%b required 1 1 0 0",
               taken_cnt, nottaken_cnt, br_busy, br_timeout);
    end
  endtask

  task automatic test_expiry_flags_win();
    br_req = 1'b1; br_type = 2'b11;
    tick();
    br_req = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    flags_valid = 1'b1; cb_in = 1'b1;
    tick();
    checks++;
    if ({pc_write_cond, br_done, br_taken, br_timeout} !== 4'b1110 || cb_sel !== 2'b11) begin
      errors++;
      $display("FAIL expiry_win: pc/done/taken/to=%b sel=%b required 1110 11",
               {pc_write_cond, br_done, br_taken, br_timeout}, cb_sel);
    end
    flags_valid = 1'b0;
    tick();
    checks++;
    if (taken_cnt !== 2'd2) begin
      errors++;
      $display("FAIL expiry_cnt: taken=%0d required 2", taken_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    seen = 6'd0;
    br_req = 1'b1; br_type = 2'b00; flags_valid = 1'b1; cb_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen[i] = br_done;
    end
    br_req = 1'b0; flags_valid = 1'b0;
    checks++;
    if (seen !== 6'b010010) begin
      errors++;
      $display("FAIL back_to_back: done pattern=%b required 010010", seen);
    end
    tick();
    checks++;
    if (nottaken_cnt !== 2'd3 || br_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cnt: nottaken=%0d busy=%b required 3 0", nottaken_cnt, br_busy);
    end
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 5; i++) do_branch(2'b10, 1'b1);
    checks++;
    if (taken_cnt !== 2'd3) begin
      errors++;
      $display("FAIL saturate: taken=%0d required 3", taken_cnt);
    end
    br_req = 1'b1; br_type = 2'b00;
    tick();
    br_req = 1'b0; flags_valid = 1'b1; cb_in = 1'b1;
    tick();
    flags_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (taken_cnt !== 2'd0 || nottaken_cnt !== 2'd0) begin
      errors++;
      $display("FAIL clr_done: taken=%0d nottaken=%0d required 0 0", taken_cnt, nottaken_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    stray = 0;
    do_branch(2'b01, 1'b1);
    br_req = 1'b1; br_type = 2'b11;
    tick();
    br_req = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (br_busy !== 1'b0 || cb_sel !== 2'b00 || taken_cnt !== 2'd0 || br_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b sel=%b taken=%0d done=%b required 0 00 0 0",
               br_busy, cb_sel, taken_cnt, br_done);
    end
    flags_valid = 1'b1; cb_in = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (br_done !== 1'b0 || pc_write_cond !== 1'b0) stray++;
    end
    flags_valid = 1'b0;
    checks++;
    if (stray != 0 || taken_cnt !== 2'd0) begin
      errors++;
      $display("FAIL post_reset: stray pulses=%0d taken=%0d required 0 0", stray, taken_cnt);
    end
    do_branch(2'b00, 1'b1);
    checks++;
    if (taken_cnt !== 2'd1) begin
      errors++;
      $display("FAIL new_branch: taken=%0d required 1", taken_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_taken_beq();
    test_not_taken_bne();
    test_timeout();
    test_expiry_flags_win();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
